// File: rtl/sprite_line_fetcher.sv
// sprite_line_fetcher: per-scanline sprite scan and ROM row fetch into the line buffer during hblank
// Ports: clk/reset (async, active-low); gl_array = NUM_ENTRIES packed {id[23:20], x[19:10], y[9:0]};
// hcount/vcount = VGA counters; rom_addr/rom_data = sprite ROM {id,row,col} -> RGB888 after ROM_LATENCY;
// lb_clear/lb_wr_en/lb_wr_addr/lb_wr_data = line buffer; busy = line in progress; overflow = too many hits.
module sprite_line_fetcher #(
  parameter int NUM_ENTRIES  = 20,
  parameter int MAX_PER_LINE = 4,
  parameter int SPRITE_DIM   = 32,
  parameter int ROM_LATENCY  = 2,
  parameter int H_ACTIVE     = 640,
  parameter int V_ACTIVE     = 480,
  parameter int V_TOTAL      = 525
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [24*NUM_ENTRIES-1:0] gl_array,
  input  logic [9:0]                hcount,
  input  logic [9:0]                vcount,
  output logic [13:0]               rom_addr,
  input  logic [23:0]               rom_data,
  output logic                      lb_clear,
  output logic                      lb_wr_en,
  output logic [9:0]                lb_wr_addr,
  output logic [23:0]               lb_wr_data,
  output logic                      busy,
  output logic                      overflow
);
  localparam int CW = $clog2(SPRITE_DIM);
  localparam int SW = $clog2(MAX_PER_LINE);
  localparam int KW = $clog2(MAX_PER_LINE + 1);
  localparam int NW = $clog2(NUM_ENTRIES);
  localparam int DW = $clog2(ROM_LATENCY + 1);
  typedef enum logic [2:0] {IDLE, SKIP, SCAN, FETCH, DRAIN, DONE} state_t;
  state_t state, state_n;
  logic h_d, trig, hit, add, issue, last_slot;
  logic [9:0] tgt, tgt_n;
  logic [23:0] shadow [NUM_ENTRIES];
  logic [23:0] e;
  logic [NW-1:0] si;
  logic [KW-1:0] cnt;
  logic [3:0] s_id [MAX_PER_LINE];
  logic [9:0] s_x [MAX_PER_LINE];
  logic [CW-1:0] s_row [MAX_PER_LINE];
  logic [SW-1:0] fs;
  logic [CW-1:0] fc;
  logic [DW-1:0] dc;
  logic [13:0] rom_q, cur;
  logic p_v [ROM_LATENCY];
  logic [10:0] p_x [ROM_LATENCY];
  assign trig = state == IDLE && hcount == 10'(H_ACTIVE) && !h_d;
  assign tgt_n = vcount == 10'(V_TOTAL - 1) ? '0 : vcount + 10'd1;
  assign e = shadow[si];
  // 11-bit compare so a sprite near the bottom never wraps onto the top lines
  assign hit = e[9:0] < 10'(V_ACTIVE) && {1'b0, e[9:0]} <= {1'b0, tgt} &&
               {1'b0, tgt} < {1'b0, e[9:0]} + 11'(SPRITE_DIM);
  assign add = hit && cnt < KW'(MAX_PER_LINE);
  assign issue = state == FETCH;
  assign last_slot = fs == SW'(cnt - 1'b1);
  assign cur = {s_id[fs], s_row[fs], fc};
  assign rom_addr = issue ? cur : rom_q;
  assign lb_clear = state == SCAN && si == '0;
  assign busy = state inside {SKIP, SCAN, FETCH, DRAIN};
  assign lb_wr_en = p_v[ROM_LATENCY-1] && rom_data != '0 && p_x[ROM_LATENCY-1] < 11'(H_ACTIVE);
  assign lb_wr_addr = lb_wr_en ? p_x[ROM_LATENCY-1][9:0] : '0;
  assign lb_wr_data = lb_wr_en ? rom_data : '0;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = trig ? (tgt_n >= 10'(V_ACTIVE) ? SKIP : SCAN) : IDLE;
      SKIP:    state_n = IDLE;
      SCAN:    state_n = si == NW'(NUM_ENTRIES - 1) ? (cnt != '0 || add ? FETCH : DONE) : SCAN;
      FETCH:   state_n = fc == '1 && last_slot ? DRAIN : FETCH;
      DRAIN:   state_n = dc == DW'(ROM_LATENCY - 1) ? DONE : DRAIN;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (trig) for (int i = 0; i < NUM_ENTRIES; i++) shadow[i] <= gl_array[24*i +: 24];
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      h_d <= 1'b0;
      tgt <= '0;
      si <= '0;
      cnt <= '0;
      fs <= '0;
      fc <= '0;
      dc <= '0;
      overflow <= 1'b0;
      rom_q <= '0;
      for (int i = 0; i < MAX_PER_LINE; i++) begin
        s_id[i] <= '0;
        s_x[i] <= '0;
        s_row[i] <= '0;
      end
      for (int i = 0; i < ROM_LATENCY; i++) begin
        p_v[i] <= 1'b0;
        p_x[i] <= '0;
      end
    end else begin
      state <= state_n;
      h_d <= hcount == 10'(H_ACTIVE);
      if (trig) begin
        tgt <= tgt_n;
        si <= '0;
        cnt <= '0;
        fs <= '0;
        fc <= '0;
        dc <= '0;
        if (tgt_n < 10'(V_ACTIVE)) overflow <= 1'b0;
      end
      if (state == SCAN) begin
        si <= si + 1'b1;
        if (add) begin
          s_id[cnt[SW-1:0]] <= e[23:20];
          s_x[cnt[SW-1:0]] <= e[19:10];
          s_row[cnt[SW-1:0]] <= CW'(tgt - e[9:0]);
          cnt <= cnt + 1'b1;
        end else if (hit) overflow <= 1'b1;
      end
      if (issue) begin
        rom_q <= cur;
        fc <= fc + 1'b1;
        if (fc == '1) fs <= fs + 1'b1;
      end
      if (state == DRAIN) dc <= dc + 1'b1;
      // x+col travels with the valid bit so each write lines up with its ROM pixel
      p_v[0] <= issue;
      p_x[0] <= 11'(s_x[fs]) + 11'(fc);
      for (int i = 1; i < ROM_LATENCY; i++) begin
        p_v[i] <= p_v[i-1];
        p_x[i] <= p_x[i-1];
      end
    end
  end
endmodule
